// File: rtl/gate_vector_checker.sv
// Built-in self-test for the 2-input gate primitive set: walks all four {in1,in2}
// vectors, samples the seven gate outputs after a settle window and accumulates results.
module gate_vector_checker #(
    parameter int unsigned SETTLE     = 2,
    parameter int unsigned NUM_PASSES = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    output logic       in1_o,
    output logic       in2_o,
    input  logic [6:0] gate_out_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [6:0] fail_mask_o,
    output logic [1:0] fail_vec_o,
    output logic [7:0] err_count_o
);

    typedef enum logic [2:0] {
        StIdle,
        StApply,
        StWait,
        StSample,
        StFin
    } state_e;

    localparam logic [3:0] WaitLoad = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
    localparam logic [7:0] LastPass = 8'(NUM_PASSES - 1);

    state_e     state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [7:0] pass_cnt_q, pass_cnt_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       in1_q, in1_d;
    logic       in2_q, in2_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [6:0] fail_mask_q, fail_mask_d;
    logic [1:0] fail_vec_q, fail_vec_d;
    logic [7:0] err_count_q, err_count_d;

    logic [6:0] golden_v;
    logic [6:0] diff;
    logic [3:0] diff_cnt;
    logic [8:0] err_sum;
    logic [7:0] err_sat;

    function automatic logic [6:0] golden(input logic [1:0] v);
        logic a;
        logic b;
        a = v[1];
        b = v[0];
        return {~a, ~(a ^ b), a ^ b, ~(a & b), a & b, ~(a | b), a | b};
    endfunction

    // Case-inequality so an unknown or floating gate output counts as a mismatch.
    always_comb begin
        golden_v = golden(vec_q);
        diff     = '0;
        diff_cnt = '0;
        for (int i = 0; i < 7; i++) begin
            diff[i]  = (gate_out_i[i] !== golden_v[i]);
            diff_cnt = diff_cnt + {3'b000, diff[i]};
        end
        err_sum = {1'b0, err_count_q} + {5'b00000, diff_cnt};
        err_sat = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        pass_cnt_d  = pass_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        in1_d       = in1_q;
        in2_d       = in2_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        fail_mask_d = fail_mask_q;
        fail_vec_d  = fail_vec_q;
        err_count_d = err_count_q;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d     = StApply;
                    busy_d      = 1'b1;
                    pass_d      = 1'b0;
                    fail_mask_d = '0;
                    fail_vec_d  = '0;
                    err_count_d = '0;
                    vec_d       = '0;
                    pass_cnt_d  = '0;
                end
            end
            StApply: begin
                {in1_d, in2_d} = vec_q;
                wait_cnt_d     = WaitLoad;
                state_d        = (SETTLE != 0) ? StWait : StSample;
            end
            StWait: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = StSample;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            StSample: begin
                fail_mask_d = fail_mask_q | diff;
                err_count_d = err_sat;
                // An all-zero sticky mask means no earlier vector of this run has failed.
                if ((diff != '0) && (fail_mask_q == '0)) begin
                    fail_vec_d = vec_q;
                end
                if (vec_q == 2'd3) begin
                    if (pass_cnt_q == LastPass) begin
                        state_d = StFin;
                    end else begin
                        pass_cnt_d = pass_cnt_q + 8'd1;
                        vec_d      = '0;
                        state_d    = StApply;
                    end
                end else begin
                    vec_d   = vec_q + 2'd1;
                    state_d = StApply;
                end
            end
            StFin: begin
                done_d  = 1'b1;
                pass_d  = (err_count_q == 8'd0);
                busy_d  = 1'b0;
                in1_d   = 1'b0;
                in2_d   = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            vec_q       <= '0;
            pass_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            in1_q       <= 1'b0;
            in2_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_mask_q <= '0;
            fail_vec_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            pass_cnt_q  <= pass_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_mask_q <= fail_mask_d;
            fail_vec_q  <= fail_vec_d;
            err_count_q <= err_count_d;
        end
    end

    assign in1_o       = in1_q;
    assign in2_o       = in2_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign fail_mask_o = fail_mask_q;
    assign fail_vec_o  = fail_vec_q;
    assign err_count_o = err_count_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Scoreboard bench for gate_vector_checker: three instances (SETTLE/NUM_PASSES variants)
// driving a behavioural gate model with injectable stuck-at and unknown-output faults.
module tb_gate_vector_checker;

    typedef struct {
        int          dut;
        int unsigned cyc;
        logic        pass;
        logic [6:0]  mask;
        logic [1:0]  vec;
        logic [7:0]  err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int          nvec = 0;
    int          nfail = 0;
    exp_t        sb[$];

    logic        start [3];
    logic        in1   [3];
    logic        in2   [3];
    logic [6:0]  gout  [3];
    logic        busy  [3];
    logic        done  [3];
    logic        pass  [3];
    logic [6:0]  fmask [3];
    logic [1:0]  fvec  [3];
    logic [7:0]  errc  [3];
    logic [6:0]  stk_en  [3];
    logic [6:0]  stk_val [3];
    logic [6:0]  x_en    [3];

    logic xprobe;
    logic x_real;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] gold(input logic a, input logic b);
        return {~a, ~(a ^ b), a ^ b, ~(a & b), a & b, ~(a | b), a | b};
    endfunction

    // On a two-state simulator an X cannot be driven, so the faulty bit is inverted instead.
    function automatic logic [6:0] model(input logic a, input logic b, input logic [6:0] se,
                                         input logic [6:0] sv, input logic [6:0] xe,
                                         input logic xr);
        logic [6:0] r;
        r = gold(a, b);
        for (int i = 0; i < 7; i++) begin
            if (se[i]) r[i] = sv[i];
            if (xe[i]) r[i] = xr ? 1'bx : ~r[i];
        end
        return r;
    endfunction

    assign gout[0] = model(in1[0], in2[0], stk_en[0], stk_val[0], x_en[0], x_real);
    assign gout[1] = model(in1[1], in2[1], stk_en[1], stk_val[1], x_en[1], x_real);
    assign gout[2] = model(in1[2], in2[2], stk_en[2], stk_val[2], x_en[2], x_real);

    gate_vector_checker #(.SETTLE(2), .NUM_PASSES(1)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start[0]), .in1_o(in1[0]), .in2_o(in2[0]),
        .gate_out_i(gout[0]), .busy_o(busy[0]), .done_o(done[0]), .pass_o(pass[0]),
        .fail_mask_o(fmask[0]), .fail_vec_o(fvec[0]), .err_count_o(errc[0])
    );

    gate_vector_checker #(.SETTLE(2), .NUM_PASSES(3)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start[1]), .in1_o(in1[1]), .in2_o(in2[1]),
        .gate_out_i(gout[1]), .busy_o(busy[1]), .done_o(done[1]), .pass_o(pass[1]),
        .fail_mask_o(fmask[1]), .fail_vec_o(fvec[1]), .err_count_o(errc[1])
    );

    gate_vector_checker #(.SETTLE(0), .NUM_PASSES(1)) u_dut_c (
        .clk_i(clk), .rst_i(rst), .start_i(start[2]), .in1_o(in1[2]), .in2_o(in2[2]),
        .gate_out_i(gout[2]), .busy_o(busy[2]), .done_o(done[2]), .pass_o(pass[2]),
        .fail_mask_o(fmask[2]), .fail_vec_o(fvec[2]), .err_count_o(errc[2])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (done[k] === 1'b1) begin
                nvec++;
                if (sb.size() == 0) begin
                    nfail++;
                    $display("FAIL unexpected_done: dut %0d pulsed done at cycle %0d, none expected",
                             k, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("done_dut", k, e.dut);
                    chk("done_cycle", cyc, e.cyc);
                    chk("pass", {31'b0, pass[k]}, {31'b0, e.pass});
                    chk("fail_mask", {25'b0, fmask[k]}, {25'b0, e.mask});
                    chk("fail_vec", {30'b0, fvec[k]}, {30'b0, e.vec});
                    chk("err_count", {24'b0, errc[k]}, {24'b0, e.err});
                    chk("busy_at_done", {31'b0, busy[k]}, 32'd0);
                end
            end
        end
    end

    task automatic push(input int k, input int unsigned at, input logic ep, input logic [6:0] em,
                        input logic [1:0] ev, input logic [7:0] ee);
        exp_t e;
        e.dut  = k;
        e.cyc  = at;
        e.pass = ep;
        e.mask = em;
        e.vec  = ev;
        e.err  = ee;
        sb.push_back(e);
    endtask

    // Pulse start for one cycle; the accepting edge is the next posedge.
    task automatic run(input int k, input int unsigned lat, input logic ep, input logic [6:0] em,
                       input logic [1:0] ev, input logic [7:0] ee);
        @(negedge clk);
        start[k] = 1'b1;
        push(k, cyc + 1 + lat, ep, em, ev, ee);
        @(negedge clk);
        start[k] = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        nvec++;
        if (sb.size() != 0) begin
            nfail++;
            $display("FAIL done_timeout: %0d expected done pulses still pending after %0d cycles",
                     sb.size(), budget);
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic clear_faults();
        for (int k = 0; k < 3; k++) begin
            stk_en[k]  = '0;
            stk_val[k] = '0;
            x_en[k]    = '0;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        xprobe = 1'bx;
        x_real = $isunknown(xprobe);
        for (int k = 0; k < 3; k++) start[k] = 1'b0;
        clear_faults();

        // Reset values on all instances
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_in1", {31'b0, in1[k]}, 32'd0);
            chk("rst_in2", {31'b0, in2[k]}, 32'd0);
            chk("rst_busy", {31'b0, busy[k]}, 32'd0);
            chk("rst_done", {31'b0, done[k]}, 32'd0);
            chk("rst_pass", {31'b0, pass[k]}, 32'd0);
            chk("rst_mask", {25'b0, fmask[k]}, 32'd0);
            chk("rst_vec", {30'b0, fvec[k]}, 32'd0);
            chk("rst_err", {24'b0, errc[k]}, 32'd0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: clean run, SETTLE=2
        run(0, 17, 1'b1, 7'b0000000, 2'b00, 8'd0);
        chk("busy_running", {31'b0, busy[0]}, 32'd1);
        drain(60);

        // 2: AND stuck-at-0, results must hold after done
        stk_en[0] = 7'b0000100;
        run(0, 17, 1'b0, 7'b0000100, 2'b11, 8'd1);
        drain(60);
        repeat (5) @(negedge clk);
        chk("hold_mask", {25'b0, fmask[0]}, 32'h04);
        chk("hold_err", {24'b0, errc[0]}, 32'd1);
        chk("hold_vec", {30'b0, fvec[0]}, 32'd3);
        chk("fin_in1_zero", {31'b0, in1[0]}, 32'd0);
        chk("fin_in2_zero", {31'b0, in2[0]}, 32'd0);
        clear_faults();

        // 3: NOT stuck-at-1, single pass and three passes
        stk_en[0] = 7'b1000000;
        stk_val[0] = 7'b1000000;
        run(0, 17, 1'b0, 7'b1000000, 2'b10, 8'd2);
        drain(60);
        stk_en[1] = 7'b1000000;
        stk_val[1] = 7'b1000000;
        run(1, 49, 1'b0, 7'b1000000, 2'b10, 8'd6);
        drain(120);
        clear_faults();

        // 4: start pulses mid-run and during FIN are ignored
        stk_en[0] = 7'b0000100;
        run(0, 17, 1'b0, 7'b0000100, 2'b11, 8'd1);
        repeat (5) @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (10) @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        drain(60);
        repeat (30) @(negedge clk);
        clear_faults();

        // Back-to-back runs with start held high
        @(negedge clk);
        start[0] = 1'b1;
        push(0, cyc + 1 + 17, 1'b1, 7'b0000000, 2'b00, 8'd0);
        push(0, cyc + 1 + 35, 1'b1, 7'b0000000, 2'b00, 8'd0);
        repeat (19) @(negedge clk);
        start[0] = 1'b0;
        drain(80);

        // 5: reset during WAIT of vector 01
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", {31'b0, busy[0]}, 32'd1);
        chk("pre_rst_vec", {30'b0, in1[0], in2[0]}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_in1", {31'b0, in1[0]}, 32'd0);
        chk("mid_rst_in2", {31'b0, in2[0]}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy[0]}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("post_rst_busy", {31'b0, busy[0]}, 32'd0);
        run(0, 17, 1'b1, 7'b0000000, 2'b00, 8'd0);
        drain(60);

        // 6: SETTLE=0, XOR output unknown on every vector
        x_en[2] = 7'b0010000;
        run(2, 9, 1'b0, 7'b0010000, 2'b00, 8'd4);
        drain(40);
        clear_faults();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
